// File: rtl/noc_eject_buffer_if.sv
// PE-side delivery bus of the NoC ejection buffer.
// master: the ejection buffer (drives flit, valid, VC; samples ready).
// slave : the processing element (samples flit, valid, VC; drives ready).
interface noc_eject_buffer_if #(
    parameter int FW = 35
);
    logic [0:FW-1] pe_data;
    logic          pe_valid;
    logic          pe_vch;
    logic          pe_ready;

    modport master (
        output pe_data,
        output pe_valid,
        output pe_vch,
        input  pe_ready
    );

    modport slave (
        input  pe_data,
        input  pe_valid,
        input  pe_vch,
        output pe_ready
    );
endinterface

// File: rtl/noc_eject_buffer.sv
// NoC ejection buffer: one FIFO per virtual channel, drained to the local PE
// with packet-atomic round-robin VC arbitration. Returns per-VC credit pulses
// (oack) and packet-in-progress flags (olck) to the router.
// Optional feature macro: NOC_EJECT_STATS_EN adds per-VC dequeue counters
// flit_cnt_0 / flit_cnt_1 (16 bit, wrapping).
// Flit type lives in idata[0:1]: 01 head, 00 body, 10 tail, 11 single.
module noc_eject_buffer #(
    parameter int DEPTH = 4,
    parameter int FW    = 35
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [0:FW-1]        idata,
    input  logic                 ivalid,
    input  logic                 ivch,
    output logic [0:1]           oack,
    output logic [0:1]           olck,
    noc_eject_buffer_if.master   pe,
    output logic                 ovf_err
`ifdef NOC_EJECT_STATS_EN
    ,
    output logic [0:15]          flit_cnt_0,
    output logic [0:15]          flit_cnt_1
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    arb_state_t          r_state, w_state_next;
    logic                r_lock_vc, w_lock_vc_next;
    logic                r_rr_ptr, w_rr_ptr_next;
    logic                r_hold;
    logic                r_hold_vc;
    logic [0:1]          r_oack;
    logic                r_ovf_err;

    logic [0:1]          w_empty;
    logic [0:1]          w_full;
    logic [0:1]          w_deq;
    logic [0:1][0:FW-1]  w_head;
    logic                w_sel;
    logic                w_valid;
    logic                w_xfer;
    logic [0:1]          w_type;
`ifdef NOC_EJECT_STATS_EN
    logic [0:1][0:15]    w_cnt;
`endif

    // Per-VC FIFO: pointers carry one extra wrap bit to tell full from empty.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vc
            logic [0:FW-1] r_mem [DEPTH];
            logic [AW:0]   r_wptr;
            logic [AW:0]   r_rptr;
            logic          w_wr;

            // Fullness is the start-of-cycle value, so a same-cycle dequeue
            // never makes room for a write into a full FIFO.
            assign w_wr        = ivalid && (ivch == 1'(gi)) && !w_full[gi];
            assign w_empty[gi] = (r_wptr == r_rptr);
            assign w_full[gi]  = (r_wptr[AW] != r_rptr[AW]) &&
                                 (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
            assign w_head[gi]  = r_mem[r_rptr[AW-1:0]];

            // Advance write pointer on accepted enqueue, read pointer on dequeue.
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_wr)
                        r_wptr <= r_wptr + (AW+1)'(1);
                    if (w_deq[gi])
                        r_rptr <= r_rptr + (AW+1)'(1);
                end
            end

            // Flit storage; contents are don't-care while the FIFO is empty.
            always_ff @(posedge clk) begin
                if (w_wr)
                    r_mem[r_wptr[AW-1:0]] <= idata;
            end

`ifdef NOC_EJECT_STATS_EN
            logic [0:15] r_cnt;

            // Count flits dequeued from this VC, wrapping at 0xFFFF.
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_)
                    r_cnt <= '0;
                else if (w_deq[gi])
                    r_cnt <= r_cnt + 16'd1;
            end

            assign w_cnt[gi] = r_cnt;
`endif
        end
    endgenerate

    // VC selection: locked VC only; else keep a stalled offer stable; else RR.
    always_comb begin
        w_sel   = r_rr_ptr;
        w_valid = 1'b0;
        if (r_state == ST_LOCK) begin
            w_sel   = r_lock_vc;
            w_valid = !w_empty[r_lock_vc];
        end else if (r_hold) begin
            w_sel   = r_hold_vc;
            w_valid = 1'b1;
        end else if (!w_empty[r_rr_ptr]) begin
            w_sel   = r_rr_ptr;
            w_valid = 1'b1;
        end else if (!w_empty[~r_rr_ptr]) begin
            w_sel   = ~r_rr_ptr;
            w_valid = 1'b1;
        end
    end

    assign w_xfer   = w_valid && pe.pe_ready;
    assign w_type   = w_head[w_sel][0:1];
    assign w_deq[0] = w_xfer && !w_sel;
    assign w_deq[1] = w_xfer && w_sel;

    // Arbiter next state: head locks, tail unlocks, single only moves the pointer.
    always_comb begin
        w_state_next   = r_state;
        w_lock_vc_next = r_lock_vc;
        w_rr_ptr_next  = r_rr_ptr;
        if (w_xfer) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_type == 2'b01) begin
                        w_state_next   = ST_LOCK;
                        w_lock_vc_next = w_sel;
                    end else if (w_type == 2'b11) begin
                        w_rr_ptr_next  = ~w_sel;
                    end
                end
                ST_LOCK: begin
                    if (w_type == 2'b10) begin
                        w_state_next  = ST_IDLE;
                        w_rr_ptr_next = ~r_lock_vc;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Arbiter state, offer-hold tracking, credit pulses and sticky overflow.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state   <= ST_IDLE;
            r_lock_vc <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_hold    <= 1'b0;
            r_hold_vc <= 1'b0;
            r_oack    <= 2'b00;
            r_ovf_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_lock_vc <= w_lock_vc_next;
            r_rr_ptr  <= w_rr_ptr_next;
            r_hold    <= w_valid && !w_xfer;
            r_hold_vc <= w_sel;
            r_oack    <= w_deq;
            if (ivalid && w_full[ivch])
                r_ovf_err <= 1'b1;
        end
    end

    assign oack        = r_oack;
    assign olck[0]     = (r_state == ST_LOCK) && !r_lock_vc;
    assign olck[1]     = (r_state == ST_LOCK) && r_lock_vc;
    assign ovf_err     = r_ovf_err;
    assign pe.pe_valid = w_valid;
    assign pe.pe_vch   = w_valid && w_sel;
    assign pe.pe_data  = w_valid ? w_head[w_sel] : '0;

`ifdef NOC_EJECT_STATS_EN
    assign flit_cnt_0 = w_cnt[0];
    assign flit_cnt_1 = w_cnt[1];
`endif
endmodule
